axis_chop_sched: RTL and testbench
==================================

// Module: axis_chop_sched
// PURPOSE
//  Round-robin burst scheduler for one AXI-S chop stage. Arbitrates NREQ burst requests (each with a
//  beat count) and sequences the chop: loads length, holds active for the burst, detects the last beat
//  delivered downstream, then releases the chop and reports completion. Drives sel_o to the upstream source mux.
// PARAMETERS
//  NREQ    2   number of requesters (>=2)
//  MAXLEN  64  max beats per burst; must match the chop stage
//  LBITS   $clog2(MAXLEN+1) (local) length/count width
//  TIMEOUT 255 watchdog limit, idle cycles between beats (used only with AXIS_SCHED_TIMEOUT_EN)
// PORTS
//  clock          in   1            system clock
//  reset          in   1            synchronous, active-high reset
//  req_valid_i    in   NREQ         burst request per requester
//  req_ready_o    out  NREQ         one-hot accept strobe (one cycle)
//  req_length_i   in   NREQ*LBITS   requested beats; requester k at [k*LBITS +: LBITS]
//  sel_o          out  NREQ         one-hot grant, steers upstream source mux; 0 when idle
//  chop_active_o  out  1            to chop active_i
//  chop_length_o  out  LBITS        to chop length_i
//  chop_final_i   in   1            from chop final_o (count reached / s_tlast accepted)
//  mon_tvalid_i   in   1            chop m_tvalid (monitor only)
//  mon_tready_i   in   1            downstream m_tready (monitor only)
//  mon_tlast_i    in   1            chop m_tlast (monitor only)
//  done_o         out  1            one-cycle completion pulse
//  done_id_o      out  $clog2(NREQ) index of completed requester, valid with done_o
//  done_count_o   out  LBITS        beats delivered downstream, valid with done_o
//  abort_o        out  1            one-cycle pulse with done_o when watchdog fired
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; RR pointer=0 (requester 0 highest priority).
//  Beat = mon_tvalid_i && mon_tready_i. End = beat && mon_tlast_i.
//  FSM (all outputs registered):
//   IDLE : any req_valid_i -> grant first valid at/after RR pointer; pulse req_ready_o[g];
//          latch g and len=min(req_length_i[g],MAXLEN); len==0 -> DONE (chop never activated, count 0);
//          else -> LOAD. chop_active_o=0.
//   LOAD : 1 cycle; chop_length_o=len, chop_active_o=0 (chop samples length while inactive); sel_o=onehot(g).
//          -> XFER.
//   XFER : chop_active_o=1, chop_length_o held, sel_o held; count beats (saturate at MAXLEN).
//          End -> DONE. chop_final_i alone does not end XFER (beats may still be buffered in the chop).
//   DONE : chop_active_o=0, sel_o=0 (flushes chop); done_o=1, done_id_o=g, done_count_o=count;
//          RR pointer <= g+1 mod NREQ; -> IDLE.
//  Latency: accept->first chop_active_o = 2 cycles; End->done_o = 1 cycle; min request-to-request = 4 cycles.
//  Requests arriving outside IDLE wait; req_valid_i must stay high until req_ready_o (not checked).
//  Early upstream s_tlast: chop ends burst short; done_count_o reports actual beats (< len).
//  Reset in any state: immediate return to IDLE, chop_active_o drops next edge, no done_o for the burst.
// CONFIGURATION
//  AXIS_SCHED_TIMEOUT_EN defined: in XFER, a cycle counter clears on every beat; reaching TIMEOUT
//   with no beat -> DONE with abort_o=1, done_count_o=beats so far; chop flushed by active drop.
//  Undefined: no watchdog logic; abort_o tied 0; XFER waits indefinitely for End.
// TESTING
//  1 single: req0 len=4, 4 beats, tready=1 -> req_ready_o=01, active 2 cyc later, done_o id=0 count=4.
//  2 RR: req0,req1 both held, len=3 -> grants 0,1,0,1 alternating; every done_count_o=3.
//  3 zero/clamp: len=0 -> done_o count=0, chop_active_o never 1; len=MAXLEN+5 -> chop_length_o=MAXLEN.
//  4 short+stall: len=8, s_tlast on beat 5, tready toggled 1/0 -> done_o after 5th delivered beat, count=5.
//  5 reset mid-XFER after 2 beats -> next cycle IDLE, active=0, no done_o; new req1 len=2 completes count=2.
//  6 (AXIS_SCHED_TIMEOUT_EN, TIMEOUT=16) tready=0 after beat 1 -> abort_o=done_o=1 16 cyc later, count=1.

Source files
------------

// File: rtl/axis_chop_sched.sv
// Round-robin burst scheduler for one AXI-S chop stage: grants a requester, loads the chop, then reports completion.
// Optional idle-beat watchdog is enabled with `define AXIS_SCHED_TIMEOUT_EN.
module axis_chop_sched #(
  parameter  int NREQ    = 2,
  parameter  int MAXLEN  = 64,
  parameter  int TIMEOUT = 255,
  localparam int LBITS   = $clog2(MAXLEN+1),
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*LBITS-1:0] req_length_i,
  output logic [NREQ-1:0]       sel_o,
  output logic                  chop_active_o,
  output logic [LBITS-1:0]      chop_length_o,
  input  logic                  chop_final_i,
  input  logic                  mon_tvalid_i,
  input  logic                  mon_tready_i,
  input  logic                  mon_tlast_i,
  output logic                  done_o,
  output logic [IDW-1:0]        done_id_o,
  output logic [LBITS-1:0]      done_count_o,
  output logic                  abort_o
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_XFER, S_DONE} state_t;

  state_t                       state, state_d;
  logic [IDW-1:0]               rr, rr_d, gid, gid_d, pick, done_id_d;
  logic [LBITS-1:0]             cnt, cnt_d, cnt_inc, pick_len, len_d, done_cnt_d;
  logic [NREQ-1:0]              ready_d, sel_d;
  logic [NREQ-1:0][LBITS-1:0]   req_len;
  logic                         found, act_d, done_d, beat, fin;

  // Burst termination is judged only from what actually left the chop; final_o may precede it.
  logic unused_final;
  assign unused_final = chop_final_i;

  assign req_len = req_length_i;
  assign beat    = mon_tvalid_i && mon_tready_i;
  assign cnt_inc = (cnt == LBITS'(MAXLEN)) ? cnt : cnt + LBITS'(1);

  function automatic int wrap(input int v);
    return (v >= NREQ) ? v - NREQ : v;
  endfunction

  function automatic logic [IDW-1:0] nxt(input logic [IDW-1:0] g);
    return (g == IDW'(NREQ-1)) ? '0 : g + IDW'(1);
  endfunction

  always_comb begin
    found = 1'b0;
    pick  = rr;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid_i[wrap(int'(rr) + i)]) begin
        found = 1'b1;
        pick  = IDW'(wrap(int'(rr) + i));
      end
    end
    pick_len = (req_len[pick] > LBITS'(MAXLEN)) ? LBITS'(MAXLEN) : req_len[pick];
  end

`ifdef AXIS_SCHED_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT+1);
  logic [WDW-1:0] wd, wd_d;
  logic           abort_d, abort_q;
  assign abort_o = abort_q;
  assign fin     = (beat && mon_tlast_i) || (!beat && wd == WDW'(TIMEOUT-1));
`else
  localparam int unused_timeout = TIMEOUT;
  assign abort_o = 1'b0;
  assign fin     = beat && mon_tlast_i;
`endif

  always_comb begin
    state_d    = state;
    rr_d       = rr;
    gid_d      = gid;
    cnt_d      = cnt;
    ready_d    = '0;
    sel_d      = sel_o;
    act_d      = chop_active_o;
    len_d      = chop_length_o;
    done_d     = 1'b0;
    done_id_d  = done_id_o;
    done_cnt_d = done_count_o;
`ifdef AXIS_SCHED_TIMEOUT_EN
    wd_d       = wd;
    abort_d    = 1'b0;
`endif
    case (state)
      S_IDLE: if (found) begin
        ready_d[pick] = 1'b1;
        gid_d         = pick;
        cnt_d         = '0;
        if (pick_len == '0) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          done_id_d  = pick;
          done_cnt_d = '0;
          rr_d       = nxt(pick);
        end else begin
          state_d     = S_LOAD;
          len_d       = pick_len;
          sel_d       = '0;
          sel_d[pick] = 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_XFER;
        act_d   = 1'b1;
`ifdef AXIS_SCHED_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_XFER: begin
        if (beat) cnt_d = cnt_inc;
`ifdef AXIS_SCHED_TIMEOUT_EN
        wd_d = beat ? '0 : wd + WDW'(1);
`endif
        if (fin) begin
          state_d    = S_DONE;
          act_d      = 1'b0;
          sel_d      = '0;
          done_d     = 1'b1;
          done_id_d  = gid;
          done_cnt_d = beat ? cnt_inc : cnt;
          rr_d       = nxt(gid);
`ifdef AXIS_SCHED_TIMEOUT_EN
          abort_d    = !(beat && mon_tlast_i);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      rr            <= '0;
      gid           <= '0;
      cnt           <= '0;
      req_ready_o   <= '0;
      sel_o         <= '0;
      chop_active_o <= 1'b0;
      chop_length_o <= '0;
      done_o        <= 1'b0;
      done_id_o     <= '0;
      done_count_o  <= '0;
`ifdef AXIS_SCHED_TIMEOUT_EN
      wd            <= '0;
      abort_q       <= 1'b0;
`endif
    end else begin
      state         <= state_d;
      rr            <= rr_d;
      gid           <= gid_d;
      cnt           <= cnt_d;
      req_ready_o   <= ready_d;
      sel_o         <= sel_d;
      chop_active_o <= act_d;
      chop_length_o <= len_d;
      done_o        <= done_d;
      done_id_o     <= done_id_d;
      done_count_o  <= done_cnt_d;
`ifdef AXIS_SCHED_TIMEOUT_EN
      wd            <= wd_d;
      abort_q       <= abort_d;
`endif
    end
  end
endmodule

// File: tb/tb_axis_chop_sched.sv
// Directed + randomized bench for axis_chop_sched; a transaction-level model predicts grants, lengths and counts.
module tb_axis_chop_sched;
  localparam int NREQ = 2, MAXLEN = 64, TMO = 16;
  localparam int LB = $clog2(MAXLEN+1);

  logic              clock = 1'b0, reset = 1'b1;
  logic [NREQ-1:0]   req_valid_i = '0, req_ready_o, sel_o;
  logic [NREQ*LB-1:0] req_length_i = '0;
  logic              chop_active_o, chop_final_i = 1'b0;
  logic [LB-1:0]     chop_length_o, done_count_o;
  logic              mon_tvalid_i = 1'b0, mon_tready_i = 1'b0, mon_tlast_i = 1'b0;
  logic              done_o, abort_o;
  logic [0:0]        done_id_o;

  int checks = 0, errors = 0, rr_m = 0;

  axis_chop_sched #(.NREQ(NREQ), .MAXLEN(MAXLEN), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_length_i(req_length_i), .sel_o(sel_o), .chop_active_o(chop_active_o),
    .chop_length_o(chop_length_o), .chop_final_i(chop_final_i), .mon_tvalid_i(mon_tvalid_i),
    .mon_tready_i(mon_tready_i), .mon_tlast_i(mon_tlast_i), .done_o(done_o),
    .done_id_o(done_id_o), .done_count_o(done_count_o), .abort_o(abort_o));

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One burst: request mask vm, lengths l0/l1, upstream tlast on beat tl (0 = none), random handshake if rnd.
  // Returns while the DUT sits in its completion cycle.
  task automatic burst(input logic [1:0] vm, input int l0, input int l1, input int tl, input bit rnd);
    int lens[2];
    int g, elen, last_k, nb;
    bit got, ended, bt;
    lens[0] = l0; lens[1] = l1;
    g = vm[rr_m] ? rr_m : 1 - rr_m;
    req_length_i = {LB'(l1), LB'(l0)};
    req_valid_i  = vm;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      if (req_ready_o != '0) got = 1;
    end
    chk("accept_seen", 32'(got), 1);
    if (!got) begin req_valid_i = '0; return; end
    chk("ready_onehot", 32'(req_ready_o), 32'(1 << g));
    req_valid_i[g] = 1'b0;
    elen = (lens[g] > MAXLEN) ? MAXLEN : lens[g];
    rr_m = (g + 1) % NREQ;
    if (elen == 0) begin
      chk("zero_done", 32'(done_o), 1);
      chk("zero_id", 32'(done_id_o), 32'(g));
      chk("zero_count", 32'(done_count_o), 0);
      chk("zero_inactive", 32'(chop_active_o), 0);
      return;
    end
    chk("load_len", 32'(chop_length_o), 32'(elen));
    chk("load_sel", 32'(sel_o), 32'(1 << g));
    chk("load_inactive", 32'(chop_active_o), 0);
    step();
    chk("xfer_active", 32'(chop_active_o), 1);
    last_k = (tl > 0 && tl < elen) ? tl : elen;
    nb = 0; ended = 0;
    for (int c = 0; c < 400 && !ended; c++) begin
      mon_tvalid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      mon_tready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      mon_tlast_i  = (nb + 1 == last_k);
      bt = mon_tvalid_i && mon_tready_i;
      step();
      if (bt) begin
        nb++;
        if (nb == last_k) ended = 1;
      end
      if (!ended) begin
        chk("no_early_done", 32'(done_o), 0);
        chk("active_hold", 32'(chop_active_o), 1);
      end
    end
    mon_tvalid_i = 1'b0; mon_tready_i = 1'b0; mon_tlast_i = 1'b0;
    chk("done", 32'(done_o), 1);
    chk("done_id", 32'(done_id_o), 32'(g));
    chk("done_count", 32'(done_count_o), 32'(last_k));
    chk("no_abort", 32'(abort_o), 0);
    chk("done_inactive", 32'(chop_active_o), 0);
    chk("done_sel", 32'(sel_o), 0);
  endtask

  initial begin
    step(); step();
    chk("rst_ready", 32'(req_ready_o), 0);
    chk("rst_sel", 32'(sel_o), 0);
    chk("rst_active", 32'(chop_active_o), 0);
    chk("rst_len", 32'(chop_length_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_abort", 32'(abort_o), 0);
    reset = 1'b0;

    burst(2'b01, 4, 0, 0, 0);
    for (int k = 0; k < 4; k++) burst(2'b11, 3, 3, 0, 0);
    burst(2'b01, 0, 0, 0, 0);
    burst(2'b10, 0, MAXLEN + 5, 0, 0);
    burst(2'b01, 8, 0, 5, 1);

    // Reset in the middle of a transfer: no completion for the dropped burst.
    req_length_i = {LB'(0), LB'(8)};
    req_valid_i  = 2'b01;
    step(); step();
    chk("rst_mid_ready", 32'(req_ready_o), 32'b01);
    req_valid_i = '0;
    step();
    mon_tvalid_i = 1'b1; mon_tready_i = 1'b1;
    step(); step();
    mon_tvalid_i = 1'b0; mon_tready_i = 1'b0;
    reset = 1'b1;
    step();
    chk("rst_mid_active", 32'(chop_active_o), 0);
    chk("rst_mid_done", 32'(done_o), 0);
    chk("rst_mid_sel", 32'(sel_o), 0);
    reset = 1'b0;
    rr_m = 0;
    step();
    chk("rst_mid_nodone", 32'(done_o), 0);
    burst(2'b10, 0, 2, 0, 0);

    for (int k = 0; k < 14; k++)
      burst(2'($urandom_range(1, 3)), int'($urandom_range(0, MAXLEN + 8)),
            int'($urandom_range(0, MAXLEN + 8)), int'($urandom_range(0, 12)), 1);

`ifdef AXIS_SCHED_TIMEOUT_EN
    // Watchdog: one beat, then the sink stalls until the scheduler gives up.
    req_length_i = {LB'(0), LB'(8)};
    req_valid_i  = 2'b01 << rr_m;
    step(); step();
    chk("tmo_ready", 32'(req_ready_o != '0), 1);
    req_valid_i = '0;
    step();
    mon_tvalid_i = 1'b1; mon_tready_i = 1'b1;
    step();
    mon_tready_i = 1'b0;
    for (int i = 1; i <= TMO; i++) begin
      step();
      if (i < TMO) chk("tmo_wait", 32'(done_o), 0);
    end
    chk("tmo_done", 32'(done_o), 1);
    chk("tmo_abort", 32'(abort_o), 1);
    chk("tmo_count", 32'(done_count_o), 1);
    mon_tvalid_i = 1'b0;
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
